// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command dispatcher: command field layout,
// opcodes, FSM states and the status byte layout.
package spi_cmd_pkg;

    localparam int CMD_W  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam int ST_ERR_ILL  = 7;
    localparam int ST_ERR_ADDR = 6;
    localparam int ST_ERR_OVR  = 5;
    localparam int ST_RSVD     = 4;
    localparam int ST_CNT_MSB  = 3;
    localparam int ST_CNT_LSB  = 0;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_WRITE  = 4'h1,
        OP_READ   = 4'h2,
        OP_STATUS = 4'h3,
        OP_CLEAR  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_WRITE, OP_READ, OP_STATUS, OP_CLEAR: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [7:0] make_status(input logic       err_ill,
                                               input logic       err_addr,
                                               input logic       err_ovr,
                                               input logic [3:0] cnt);
        logic [7:0] s;
        s                         = 8'h00;
        s[ST_ERR_ILL]             = err_ill;
        s[ST_ERR_ADDR]            = err_addr;
        s[ST_ERR_OVR]             = err_ovr;
        s[ST_RSVD]                = 1'b0;
        s[ST_CNT_MSB:ST_CNT_LSB]  = cnt;
        return s;
    endfunction

    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [3:0] addr,
                                             input logic [7:0] data);
        return {op, addr, data};
    endfunction

endpackage

// File: rtl/spi_cmd_dispatch_reg_bank.sv
// NUM_REGS x 8-bit register array: synchronous write and clear-all,
// combinational read port, flattened view of the whole bank.
module spi_reg_bank
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    clr,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic [NUM_REGS*8-1:0]   regs
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Register storage: reset and clear both restore RST_VAL, writes hit one entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs_r[i] <= RST_VAL;
            end else if (clr) begin
                regs_r[i] <= RST_VAL;
            end else if (wr_en && (wr_addr == 4'(i))) begin
                regs_r[i] <= wr_data;
            end else begin
                regs_r[i] <= regs_r[i];
            end
        end
    end

    // Read mux built as an OR of one-hot selects; unmapped addresses read 0
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data = rd_data | ({8{rd_addr == 4'(i)}} & regs_r[i]);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[8*g +: 8] = regs_r[g];
    end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// Command decoder behind the SPI slave: latches a command at the end of each
// frame, executes it against the register bank and prepares the response word.
module spi_cmd_dispatch
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cmd,
    input  logic                  cmd_rdy,
    output logic [15:0]           resp,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_pulse,
    output logic [3:0]            wr_addr,
    output logic                  busy
);

    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    state_e        state_r;
    state_e        state_s;
    logic          accept_s;
    logic          cmd_rdy_q_r;
    logic          rise_s;
    logic          fall_s;
    logic [15:0]   cmd_lat_r;
    logic [3:0]    cmd_cnt_r;
    logic          err_ill_r;
    logic          err_addr_r;
    logic          err_ovr_r;
    logic [15:0]   resp_r;
    logic [15:0]   resp_s;
    logic          wr_pulse_r;
    logic [3:0]    wr_addr_r;
    logic          busy_r;

    logic [3:0]    op_s;
    logic [3:0]    addr_s;
    logic [7:0]    data_s;
    logic          mapped_s;
    logic          in_wr_ok_s;
    logic          exec_s;
    logic          bank_wr_s;
    logic          bank_clr_s;
    logic          rd_unmapped_s;
    logic [7:0]    rd_data_s;

    assign rise_s = cmd_rdy & ~cmd_rdy_q_r;
    assign fall_s = ~cmd_rdy & cmd_rdy_q_r;

    assign op_s     = cmd_lat_r[OP_MSB:OP_LSB];
    assign addr_s   = cmd_lat_r[ADDR_MSB:ADDR_LSB];
    assign data_s   = cmd_lat_r[DATA_MSB:DATA_LSB];
    assign mapped_s = ({1'b0, addr_s} < NUM_REGS_W);

    // Decoded from the live cmd so wr_pulse/wr_addr are already valid during EXEC
    assign in_wr_ok_s = (cmd[OP_MSB:OP_LSB] == OP_WRITE) &&
                        ({1'b0, cmd[ADDR_MSB:ADDR_LSB]} < NUM_REGS_W);

    assign exec_s     = (state_r == EXEC);
    assign bank_wr_s  = exec_s && (op_s == OP_WRITE) && mapped_s;
    assign bank_clr_s = exec_s && (op_s == OP_CLEAR);

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .RST_VAL  (RST_VAL)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_wr_s),
        .clr     (bank_clr_s),
        .wr_addr (addr_s),
        .wr_data (data_s),
        .rd_addr (addr_s),
        .rd_data (rd_data_s),
        .regs    (regs)
    );

    // Next-state logic; a rise outside IDLE is dropped
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_s  = EXEC;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            EXEC:    state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Response word for the latched command
    always_comb begin
        resp_s        = {op_s, addr_s, 8'h00};
        rd_unmapped_s = 1'b0;
        case (op_s)
            OP_READ: begin
                if (mapped_s) begin
                    resp_s = {OP_READ, addr_s, rd_data_s};
                end else begin
                    resp_s        = {OP_READ, addr_s, 8'h00};
                    rd_unmapped_s = 1'b1;
                end
            end
            OP_STATUS: resp_s = {OP_STATUS, 4'h0,
                                 make_status(err_ill_r, err_addr_r, err_ovr_r, cmd_cnt_r)};
            default:   resp_s = {op_s, addr_s, 8'h00};
        endcase
    end

    // FSM, frame edge detect, command latch and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_rdy_q_r <= 1'b1;
            cmd_lat_r   <= 16'h0000;
            resp_r      <= 16'h0000;
            wr_pulse_r  <= 1'b0;
            wr_addr_r   <= 4'h0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_rdy_q_r <= cmd_rdy;
            busy_r      <= (state_s != IDLE);
            wr_pulse_r  <= accept_s & in_wr_ok_s;
            if (accept_s) begin
                cmd_lat_r <= cmd;
            end
            if (accept_s && in_wr_ok_s) begin
                wr_addr_r <= cmd[ADDR_MSB:ADDR_LSB];
            end
            if (state_r == RESP) begin
                resp_r <= resp_s;
            end
        end
    end

    // Command counter and sticky error flags; an overrun seen during CLEAR still sticks
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_cnt_r  <= 4'h0;
            err_ill_r  <= 1'b0;
            err_addr_r <= 1'b0;
            err_ovr_r  <= 1'b0;
        end else begin
            if (bank_clr_s) begin
                cmd_cnt_r <= 4'h0;
            end else if (exec_s) begin
                cmd_cnt_r <= cmd_cnt_r + 4'd1;
            end
            err_ill_r  <= ~bank_clr_s & (err_ill_r | (exec_s & ~is_legal_op(op_s)));
            err_addr_r <= ~bank_clr_s & (err_addr_r
                          | (exec_s & (op_s == OP_WRITE) & ~mapped_s)
                          | ((state_r == RESP) & rd_unmapped_s));
            err_ovr_r  <= (err_ovr_r & ~bank_clr_s) | (fall_s & busy_r);
        end
    end

    assign resp     = resp_r;
    assign wr_pulse = wr_pulse_r;
    assign wr_addr  = wr_addr_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Randomised scoreboard bench for spi_cmd_dispatch with a frame-level reference model.
module tb_spi_cmd_dispatch;
    import spi_cmd_pkg::*;

    localparam int NUM_REGS = 8;
    localparam int RW = NUM_REGS * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   cmd;
    logic          cmd_rdy;
    logic [15:0]   resp;
    logic [RW-1:0] regs;
    logic          wr_pulse;
    logic [3:0]    wr_addr;
    logic          busy;

    spi_cmd_dispatch #(.NUM_REGS(NUM_REGS), .RST_VAL(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .cmd_rdy  (cmd_rdy),
        .resp     (resp),
        .regs     (regs),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [15:0]   resp;
        logic [RW-1:0] regs;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [3:0] addr;
        int         cyc;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    // reference model state
    logic [7:0] m_regs [16];
    int         m_cnt;
    bit         m_ill, m_addr, m_ovr;
    int         m_last;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_cnt  = 0;
        m_ill  = 1'b0;
        m_addr = 1'b0;
        m_ovr  = 1'b0;
        m_last = -100;
    endfunction

    // Frame seen by the model: rise at cycle r, cmd_rdy held high for g cycles.
    // The dispatcher is busy for the two cycles after an accepted rise.
    function automatic void model_frame(input logic [15:0] c, input int r, input int g);
        logic [3:0] op, a;
        logic [7:0] d;
        bit         mapped;
        exp_t       e;
        wr_t        w;
        op = c[15:12];
        a  = c[11:8];
        d  = c[7:0];
        mapped = (int'(a) < NUM_REGS);
        if (r <= m_last + 2) return;
        m_last = r;
        if (op == 4'h1) begin
            if (mapped) begin
                m_regs[a] = d;
                w.addr = a;
                w.cyc  = r + 1;
                wr_q.push_back(w);
            end else begin
                m_addr = 1'b1;
            end
        end else if (op == 4'hF) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_ill  = 1'b0;
            m_addr = 1'b0;
            m_ovr  = 1'b0;
        end else if (!(op inside {4'h0, 4'h2, 4'h3})) begin
            m_ill = 1'b1;
        end
        m_cnt = (op == 4'hF) ? 0 : (m_cnt + 1) % 16;
        if (g == 1) m_ovr = 1'b1;
        if (op == 4'h2) begin
            if (mapped) e.resp = {4'h2, a, m_regs[a]};
            else        e.resp = {4'h2, a, 8'h00};
        end else if (op == 4'h3) begin
            e.resp = {4'h3, 4'h0, m_ill, m_addr, m_ovr, 1'b0, 4'(m_cnt)};
        end else begin
            e.resp = {op, a, 8'h00};
        end
        if (op == 4'h2 && !mapped) m_addr = 1'b1;
        if (g == 2) m_ovr = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) e.regs[8*i +: 8] = m_regs[i];
        e.cyc = r + 3;
        exp_q.push_back(e);
    endfunction

    task automatic send_frame(input logic [15:0] c, input int low, input int high);
        repeat (low) begin
            @(posedge clk); #1;
            cmd_rdy = 1'b0;
            cmd     = 16'($urandom);
        end
        @(posedge clk); #1;
        cmd_rdy = 1'b1;
        cmd     = c;
        model_frame(c, cyc, high);
        repeat (high - 1) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst     = 1'b1;
        cmd_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Monitor: pops expectations when a write strobe or end-of-command appears
    initial begin
        bit   prev_busy;
        exp_t e;
        wr_t  w;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_pulse) begin
                    if (wr_q.size() == 0) begin
                        check(1'b0, "wr_pulse_unexpected", 64'(wr_addr), 64'hFFFF);
                    end else begin
                        w = wr_q.pop_front();
                        check(wr_addr == w.addr, "wr_addr", 64'(wr_addr), 64'(w.addr));
                        check(cyc == w.cyc, "wr_pulse_cycle", 64'(cyc), 64'(w.cyc));
                    end
                end
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "resp_unexpected", 64'(resp), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check(resp == e.resp, "resp", 64'(resp), 64'(e.resp));
                        check(regs == e.regs, "regs", 64'(regs), 64'(e.regs));
                        check(cyc == e.cyc, "resp_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        logic [15:0] c;
        logic [3:0]  op;
        int          k, g;
        model_reset();
        rst     = 1'b1;
        cmd_rdy = 1'b1;
        cmd     = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        check(resp == 16'h0000, "reset_resp", 64'(resp), 64'h0);
        check(busy == 1'b0, "reset_busy", 64'(busy), 64'h0);
        check(wr_pulse == 1'b0, "reset_wr_pulse", 64'(wr_pulse), 64'h0);
        check(wr_addr == 4'h0, "reset_wr_addr", 64'(wr_addr), 64'h0);
        check(regs == '0, "reset_regs", 64'(regs), 64'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check(busy == 1'b0, "idle_after_reset", 64'(busy), 64'h0);

        // write then read back
        send_frame(make_cmd(OP_WRITE, 4'h3, 8'hA5), 3, 5);
        #2 check(regs[31:24] == 8'hA5, "reg3_written", 64'(regs[31:24]), 64'hA5);
        send_frame(make_cmd(OP_READ, 4'h3, 8'h00), 3, 5);
        #2 check(resp == 16'h23A5, "read_reg3", 64'(resp), 64'h23A5);

        // unmapped write then status
        do_reset();
        send_frame(make_cmd(OP_WRITE, 4'h9, 8'h55), 2, 5);
        send_frame(make_cmd(OP_STATUS, 4'h0, 8'h00), 2, 5);
        #2 check(resp == 16'h3042, "status_err_addr", 64'(resp), 64'h3042);

        // illegal, clear, status
        send_frame(16'h7000, 2, 5);
        send_frame(make_cmd(OP_CLEAR, 4'h0, 8'h00), 2, 5);
        send_frame(make_cmd(OP_STATUS, 4'h0, 8'h00), 2, 5);
        #2 check(resp == 16'h3001, "status_after_clear", 64'(resp), 64'h3001);

        // overrun: short high period, second rise lands while busy
        send_frame(make_cmd(OP_NOP, 4'h0, 8'h00), 2, 1);
        send_frame(make_cmd(OP_WRITE, 4'h2, 8'h77), 1, 5);
        send_frame(make_cmd(OP_STATUS, 4'h0, 8'h00), 2, 5);
        #2 check(resp == 16'h3023, "status_overrun", 64'(resp), 64'h3023);
        check(regs[23:16] == 8'h00, "dropped_write", 64'(regs[23:16]), 64'h0);

        // counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) send_frame(make_cmd(OP_NOP, 4'h0, 8'h00), 1, 4);
        send_frame(make_cmd(OP_STATUS, 4'h0, 8'h00), 1, 5);
        #2 check(resp == 16'h3002, "status_wrap", 64'(resp), 64'h3002);

        // reset during EXEC of a write aborts it
        do_reset();
        @(posedge clk); #1 cmd_rdy = 1'b0;
        @(posedge clk); #1 cmd_rdy = 1'b1; cmd = make_cmd(OP_WRITE, 4'h5, 8'h3C);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 check(regs[47:40] == 8'h00, "reset_aborts_write", 64'(regs[47:40]), 64'h0);

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0:       op = OP_NOP;
                1, 2, 3: op = OP_WRITE;
                4, 5:    op = OP_READ;
                6:       op = OP_STATUS;
                7:       op = OP_CLEAR;
                8:       op = 4'($urandom_range(4, 14));
                default: op = OP_STATUS;
            endcase
            c = make_cmd(op, 4'($urandom_range(0, 15)), 8'($urandom));
            g = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 6);
            send_frame(c, $urandom_range(1, 4), g);
        end
        send_frame(make_cmd(OP_STATUS, 4'h0, 8'h00), 2, 6);
        repeat (10) @(posedge clk);
        #2;
        check(exp_q.size() == 0, "resp_queue_drained", 64'(exp_q.size()), 64'h0);
        check(wr_q.size() == 0, "wr_queue_drained", 64'(wr_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
